// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP: controller states,
// instruction opcodes and the TAP next-state function.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SHIFT_DR = 4'h4,
        ST_EXIT1_DR = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EXIT2_DR = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'hA,
        ST_SHIFT_IR = 4'hB,
        ST_EXIT1_IR = 4'hC,
        ST_PAUSE_IR = 4'hD,
        ST_EXIT2_IR = 4'hE,
        ST_UPD_IR   = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } dr_sel_t;

    localparam logic [3:0] IR_IDCODE  = 4'b0010;
    localparam logic [3:0] IR_USER    = 4'b1000;
    localparam logic [3:0] IR_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    function automatic tap_state_t tap_next(tap_state_t s, logic tms);
        tap_state_t n;
        n = ST_TLR;
        case (s)
            ST_TLR:      n = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      n = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   n = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: n = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: n = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: n = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   n = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   n = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: n = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: n = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: n = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   n = tms ? ST_SEL_DR   : ST_RTI;
            default:     n = ST_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; the state decodes are registered alongside the
// state so each flag is high exactly while the controller sits in that state.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);

    tap_state_t state_q;
    tap_state_t state_d;
    logic tlr_q;
    logic captureDr_q;
    logic shiftDr_q;
    logic updateDr_q;
    logic captureIr_q;
    logic shiftIr_q;
    logic updateIr_q;

    assign state_d = tap_next(state_q, tms_i);

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q     <= ST_TLR;
            tlr_q       <= 1'b1;
            captureDr_q <= 1'b0;
            shiftDr_q   <= 1'b0;
            updateDr_q  <= 1'b0;
            captureIr_q <= 1'b0;
            shiftIr_q   <= 1'b0;
            updateIr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tlr_q       <= (state_d == ST_TLR);
            captureDr_q <= (state_d == ST_CAP_DR);
            shiftDr_q   <= (state_d == ST_SHIFT_DR);
            updateDr_q  <= (state_d == ST_UPD_DR);
            captureIr_q <= (state_d == ST_CAP_IR);
            shiftIr_q   <= (state_d == ST_SHIFT_IR);
            updateIr_q  <= (state_d == ST_UPD_IR);
        end
    end

    assign tlr_o        = tlr_q;
    assign capture_dr_o = captureDr_q;
    assign shift_dr_o   = shiftDr_q;
    assign update_dr_o  = updateDr_q;
    assign capture_ir_o = captureIr_q;
    assign shift_ir_o   = shiftIr_q;
    assign update_ir_o  = updateIr_q;

endmodule

// File: rtl/jtag_tap_top.sv
// JTAG TAP top: instruction register, IDCODE/BYPASS/USER data registers
// and the falling-edge TDO launch.
module jtag_tap_top
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IR_LEN       = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
    parameter logic [31:0] USER_RESET   = 32'h00000000
) (
    input  logic tck_pad_i,
    input  logic rst_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o
);

    logic tlr;
    logic captureDr;
    logic shiftDr;
    logic updateDr;
    logic captureIr;
    logic shiftIr;
    logic updateIr;

    logic [IR_LEN-1:0] ir_q;
    logic [IR_LEN-1:0] irShift_q;
    logic [31:0]       drShift_q;
    logic [31:0]       user_q;
    logic              bypass_q;
    logic              tdo_q;
    dr_sel_t           drSel;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_pad_i),
        .rst_i        (rst_i),
        .tms_i        (tms_pad_i),
        .tlr_o        (tlr),
        .capture_dr_o (captureDr),
        .shift_dr_o   (shiftDr),
        .update_dr_o  (updateDr),
        .capture_ir_o (captureIr),
        .shift_ir_o   (shiftIr),
        .update_ir_o  (updateIr)
    );

    // Unknown opcodes fall back to BYPASS so TDI always has a 1-bit path to TDO.
    always_comb begin
        drSel = SEL_BYPASS;
        if (ir_q == IR_LEN'(IR_IDCODE)) begin
            drSel = SEL_IDCODE;
        end else if (ir_q == IR_LEN'(IR_USER)) begin
            drSel = SEL_USER;
        end
    end

    always_ff @(posedge tck_pad_i) begin
        if (rst_i) begin
            ir_q      <= IR_LEN'(IR_IDCODE);
            irShift_q <= '0;
        end else begin
            if (captureIr) begin
                irShift_q <= IR_LEN'(IR_CAPTURE);
            end else if (shiftIr) begin
                irShift_q <= {tdi_pad_i, irShift_q[IR_LEN-1:1]};
            end
            if (tlr) begin
                ir_q <= IR_LEN'(IR_IDCODE);
            end else if (updateIr) begin
                ir_q <= irShift_q;
            end
        end
    end

    always_ff @(posedge tck_pad_i) begin
        if (rst_i) begin
            drShift_q <= '0;
            bypass_q  <= 1'b0;
            user_q    <= USER_RESET;
        end else begin
            if (captureDr) begin
                case (drSel)
                    SEL_IDCODE: drShift_q <= IDCODE_VALUE;
                    SEL_USER:   drShift_q <= user_q;
                    default:    bypass_q  <= 1'b0;
                endcase
            end else if (shiftDr) begin
                if (drSel == SEL_BYPASS) begin
                    bypass_q <= tdi_pad_i;
                end else begin
                    drShift_q <= {tdi_pad_i, drShift_q[31:1]};
                end
            end
            if (updateDr && drSel == SEL_USER) begin
                user_q <= drShift_q;
            end
        end
    end

    // Launching on the falling edge gives the host a half-cycle of setup.
    always_ff @(negedge tck_pad_i) begin
        if (rst_i) begin
            tdo_q <= 1'b0;
        end else if (shiftIr) begin
            tdo_q <= irShift_q[0];
        end else if (shiftDr) begin
            tdo_q <= (drSel == SEL_BYPASS) ? bypass_q : drShift_q[0];
        end else begin
            tdo_q <= 1'b0;
        end
    end

    assign tdo_pad_o = tdo_q;

endmodule

// File: tb/tb_jtag_tap_top.sv
// Directed bench for jtag_tap_top: drives TMS/TDI between falling and rising
// TCK edges and compares TDO against hand-computed scan results.
module tb_jtag_tap_top;

    logic tck;
    logic rst;
    logic tms;
    logic tdi;
    logic tdo;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    jtag_tap_top dut (
        .tck_pad_i (tck),
        .rst_i     (rst),
        .tms_pad_i (tms),
        .tdi_pad_i (tdi),
        .tdo_pad_o (tdo)
    );

    initial tck = 1'b0;
    always #10 tck = ~tck;

    // One TCK: returns the TDO launched on the previous falling edge, then
    // clocks tms/tdi in and parks just after the next falling edge.
    task automatic applyStimulus(input logic tmsIn, input logic tdiIn, output logic tdoOut);
        tdoOut = tdo;
        tms = tmsIn;
        tdi = tdiIn;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic scanDr(input logic [63:0] dataIn, input int len, output logic [31:0] dataOut);
        logic t;
        dataOut = '0;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < len; i++) begin
            applyStimulus(i == len - 1, dataIn[i], t);
            if (i < 32) dataOut[i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic scanIr(input logic [3:0] irIn, output logic [3:0] irOut);
        logic t;
        irOut = '0;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, irIn[i], t);
            irOut[i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic test_reset();
        logic t;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_tdo: got %b expected 0", tdo);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, t);
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rti_tdo: got %b expected 0", tdo);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] o;
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== IDCODE) begin
            fails++;
            $display("[TB] FAIL idcode_read: got %h expected %h", o, IDCODE);
        end
    endtask

    task automatic test_ir_capture();
        logic [3:0] o;
        scanIr(4'b1111, o);
        tests++;
        if (o !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL ir_capture: got %b expected 0101", o);
        end
    endtask

    task automatic test_bypass();
        logic t;
        logic tdiSeq[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic expSeq[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, tdiSeq[i], t);
            tests++;
            if (t !== expSeq[i]) begin
                fails++;
                $display("[TB] FAIL bypass_bit%0d: got %b expected %b", i, t, expSeq[i]);
            end
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic test_user();
        logic [3:0]  ir;
        logic [31:0] o;
        scanIr(4'b1000, ir);
        scanDr({32'h0, 32'hDEADBEEF}, 32, o);
        tests++;
        if (o !== 32'h00000000) begin
            fails++;
            $display("[TB] FAIL user_reset_value: got %h expected 00000000", o);
        end
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== 32'hDEADBEEF) begin
            fails++;
            $display("[TB] FAIL user_readback: got %h expected deadbeef", o);
        end
        scanDr({28'h0, 32'h12345678, 4'hA}, 36, o);
        scanDr(64'hFF, 8, o);
        tests++;
        if (o !== 32'h00000078) begin
            fails++;
            $display("[TB] FAIL user_overlong: got %h expected 00000078", o);
        end
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== 32'hFF123456) begin
            fails++;
            $display("[TB] FAIL user_partial: got %h expected ff123456", o);
        end
    endtask

    task automatic test_pause();
        logic        t;
        logic [31:0] d;
        logic [31:0] o;
        d = 32'hA5A55A5A;
        o = '0;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 15, d[i], t);
            o[i] = t;
        end
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 16; i < 32; i++) begin
            applyStimulus(i == 31, d[i], t);
            o[i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        tests++;
        if (o !== 32'h00000000) begin
            fails++;
            $display("[TB] FAIL pause_shift_out: got %h expected 00000000", o);
        end
        scanDr(64'hFFFFFFFF, 32, o);
        tests++;
        if (o !== 32'hA5A55A5A) begin
            fails++;
            $display("[TB] FAIL pause_readback: got %h expected a5a55a5a", o);
        end
    endtask

    task automatic test_tms_reset();
        logic        t;
        logic [3:0]  ir;
        logic [31:0] o;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, t);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, t);
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL tms_reset_tdo: got %b expected 0", tdo);
        end
        applyStimulus(1'b0, 1'b0, t);
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== IDCODE) begin
            fails++;
            $display("[TB] FAIL tms_reset_ir: got %h expected %h", o, IDCODE);
        end
        scanIr(4'b1000, ir);
        scanDr({32'h0, 32'hCAFEF00D}, 32, o);
        tests++;
        if (o !== 32'hFFFFFFFF) begin
            fails++;
            $display("[TB] FAIL tms_reset_user: got %h expected ffffffff", o);
        end
    endtask

    task automatic test_sync_reset();
        logic        t;
        logic [3:0]  ir;
        logic [31:0] o;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, t);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, t);
        rst = 1'b0;
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sync_reset_tdo_tlr: got %b expected 0", tdo);
        end
        applyStimulus(1'b0, 1'b0, t);
        tests++;
        if (tdo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sync_reset_tdo_rti: got %b expected 0", tdo);
        end
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== IDCODE) begin
            fails++;
            $display("[TB] FAIL sync_reset_ir: got %h expected %h", o, IDCODE);
        end
        scanIr(4'b1000, ir);
        scanDr(64'h0, 32, o);
        tests++;
        if (o !== 32'h00000000) begin
            fails++;
            $display("[TB] FAIL sync_reset_user: got %h expected 00000000", o);
        end
    endtask

    initial begin
        rst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        @(negedge tck);
        #1;
        test_reset();
        test_idcode();
        test_ir_capture();
        test_bypass();
        test_user();
        test_pause();
        test_tms_reset();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
